coin_sender: RTL
================

COIN_SENDER -- requirements
Module: coin_sender

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, stable-sample count required to accept a button level change (legal 2..255).
REQ-002 Port: clock  input  1  single system clock, all state on rising edge.
REQ-003 Port: reset_L  input  1  reset, asynchronous and active-low.
REQ-004 Port: insert_L  input  1  raw coin-insert pushbutton, active-low, asynchronous to clock, bouncy.
REQ-005 Port: coin_sel  input  2  coin code to send: 00 = none, 01/10/11 = coin codes understood by the vending FSM.
REQ-006 Port: drop  input  1  drop indication returned by the vending FSM.
REQ-007 Port: coin  output  2  coin code presented to the vending FSM; 00 except in the single send cycle.
REQ-008 Port: busy  output  1  high while a press is being debounced, sent, or awaiting release.
REQ-009 Port: coins_sent  output  8  count of non-00 codes emitted, saturating.
REQ-010 Port: value_sent  output  8  sum of numeric values (1/2/3) of emitted codes, saturating.
REQ-011 Port: drops_seen  output  4  count of drop rising edges, wrapping.

Function
REQ-012 insert_L shall pass through a 2-flop synchronizer; all logic shall use only the synchronized level (press = synchronized 0).
REQ-013 FSM states: IDLE, DEB_PRESS, SEND, WAIT_REL, DEB_REL.
REQ-014 IDLE: synchronized press -> DEB_PRESS, debounce counter cleared; busy = 0 only in IDLE.
REQ-015 DEB_PRESS: counter increments each cycle the level stays pressed; any released sample -> IDLE; count reaching DEBOUNCE_CYCLES -> SEND.
REQ-016 SEND: lasts exactly one cycle; coin shall equal coin_sel sampled in that cycle; -> WAIT_REL.
REQ-017 coin shall be 00 in every state other than SEND; exactly one send per accepted press regardless of hold duration.
REQ-018 SEND with coin_sel = 00 shall emit 00 and shall not change coins_sent or value_sent.
REQ-019 WAIT_REL: synchronized release -> DEB_REL, counter cleared.
REQ-020 DEB_REL: counter increments while released; any pressed sample -> WAIT_REL; count reaching DEBOUNCE_CYCLES -> IDLE.
REQ-021 Latency: press stable from its first synchronized cycle yields coin in cycle 2 (sync) + DEBOUNCE_CYCLES + 1 after the falling edge of insert_L.
REQ-022 coins_sent increments by 1 and value_sent by the code value, registered, in the cycle after SEND; both saturate at 255 and never wrap.
REQ-023 drop shall be edge-detected (registered previous value); drops_seen increments on each 0->1 edge, wraps 15->0.
REQ-024 drop shall not stall or alter the FSM; a SEND coincident with a drop edge shall still emit its code and both counters shall update.
REQ-025 coin_sel changes outside SEND shall have no effect.

Reset
REQ-026 reset_L low shall immediately force: state IDLE, synchronizer flops to released (1), debounce counter 0, coin 00, busy 0, coins_sent 0, value_sent 0, drops_seen 0, drop-edge register 0.
REQ-027 Reset asserted mid-debounce or during SEND shall abort without emitting or counting a coin; deassertion resumes in IDLE.
REQ-028 A button held through reset deassertion shall be treated as a new press (debounced, then sent once).

Verification
REQ-029 Clean press, coin_sel=10, DEBOUNCE_CYCLES=4, held 20 cycles -> coin=10 for exactly one cycle at edge+7, coins_sent=1, value_sent=2.
REQ-030 Bounce: insert_L toggling every cycle for 10 cycles then released -> coin stays 00, counters unchanged, busy returns 0.
REQ-031 Release bounce: clean press, release with 2 single-cycle re-presses -> exactly one coin emitted, busy low only after DEBOUNCE_CYCLES stable release.
REQ-032 Saturation: 90 presses with coin_sel=11 -> coins_sent=90, value_sent=255.
REQ-033 drop pulsed 17 times, one pulse coincident with a SEND -> drops_seen=1, that coin still emitted and counted.
REQ-034 reset_L asserted during DEB_PRESS -> all outputs zero within the same cycle, no coin; held button after release of reset -> one coin.

Source files
------------

// File: rtl/coin_sender.sv
// coin_sender: debounced coin-insert button emitting one coin code per press,
// with saturating send/value counters and a wrapping drop-edge counter.
module coin_sender #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       insert_L,
    input  logic [1:0] coin_sel,
    input  logic       drop,
    output logic [1:0] coin,
    output logic       busy,
    output logic [7:0] coins_sent,
    output logic [7:0] value_sent,
    output logic [3:0] drops_seen
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        SEND,
        WAIT_REL,
        DEB_REL
    } state_e;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sync1_q, sync2_q;
    logic       drop_q;
    logic [7:0] coins_q, coins_d;
    logic [7:0] value_q, value_d;
    logic [3:0] drops_q, drops_d;
    logic       pressed;
    logic       send_fire;
    logic [7:0] cnt_inc;
    logic [8:0] value_sum;

    assign pressed = ~sync2_q;
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= insert_L;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coin    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LAST) state_d = SEND;
                end
            end
            SEND: begin
                coin    = coin_sel;
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!pressed) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (pressed) begin
                    state_d = WAIT_REL;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A 00 code in SEND is a no-op send and leaves both counters alone.
    assign send_fire = (state_q == SEND) && (coin_sel != 2'b00);
    assign value_sum = {1'b0, value_q} + {7'b0, coin_sel};

    always_comb begin
        coins_d = coins_q;
        value_d = value_q;
        drops_d = drops_q + {3'b0, drop & ~drop_q};
        if (send_fire) begin
            coins_d = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
            value_d = value_sum[8] ? 8'hFF : value_sum[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            coins_q <= '0;
            value_q <= '0;
            drops_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            coins_q <= coins_d;
            value_q <= value_d;
            drops_q <= drops_d;
            drop_q  <= drop;
        end
    end

    assign busy       = (state_q != IDLE);
    assign coins_sent = coins_q;
    assign value_sent = value_q;
    assign drops_seen = drops_q;

endmodule
